// File: rtl/raster_scheduler.sv
// Frame-level controller for the 4-pixel-per-cycle raster generator: validates the frame size,
// steps the generator one beat per issue, and throttles issue with FIFO credits.
module raster_scheduler #(
  parameter  int FIFO_DEPTH = 32,
  parameter  int CW         = 10,
  localparam int CRW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           start,
  input  logic           abort,
  input  logic [15:0]    width,
  input  logic [15:0]    height,
  input  logic           retire,
  output logic           gen_clr,
  output logic           gen_en,
  output logic           issue_valid,
  output logic           issue_sof,
  output logic           issue_eol,
  output logic [CW-1:0]  x_base,
  output logic [CW-1:0]  y_cur,
  output logic [CRW-1:0] credits,
  output logic           busy,
  output logic           done,
  output logic           cfg_err,
  output logic           proto_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  localparam logic [16:0]    MAX_DIM = 17'(2 ** CW);
  localparam logic [CRW-1:0] FULL    = CRW'(FIFO_DEPTH);

  state_t         state_q, state_d;
  logic [CRW-1:0] credits_q;
  logic [CW-1:0]  x_q, y_q;
  logic [15:0]    w_q, h_q;
  logic           done_q, cfg_err_q, proto_q;
  logic           issue, size_ok, x_last, y_last, full, ret_ok;

  assign full    = (credits_q == FULL);
  assign issue   = aresetn && (state_q == RUN) && (credits_q != '0) && !abort;
  // A retire only counts if it has somewhere to go; the issue in the same cycle makes room.
  assign ret_ok  = retire && (!full || issue);
  assign x_last  = (16'(x_q) == (w_q - 16'd4));
  assign y_last  = (16'(y_q) == (h_q - 16'd1));
  assign size_ok = (width != 16'd0) && (width[1:0] == 2'b00) && ({1'b0, width} <= MAX_DIM) &&
                   (height != 16'd0) && ({1'b0, height} <= MAX_DIM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = size_ok ? RUN : IDLE;
      RUN:     if (abort || (issue && x_last && y_last)) state_d = DRAIN;
      DRAIN:   if (full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      credits_q <= FULL;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= (state_q == DRAIN) && full;
      cfg_err_q <= (state_q == LOAD) && !size_ok;

      if (issue && !ret_ok)      credits_q <= credits_q - CRW'(1);
      else if (!issue && ret_ok) credits_q <= credits_q + CRW'(1);

      if (state_q == LOAD) begin
        w_q     <= width;
        h_q     <= height;
        x_q     <= '0;
        y_q     <= '0;
        proto_q <= 1'b0;
      end else if (issue) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= y_q + CW'(1);
        end else begin
          x_q <= x_q + CW'(4);
        end
      end

      if (retire && full && !issue) proto_q <= 1'b1;
    end
  end

  assign gen_clr     = !aresetn || (state_q == LOAD);
  assign gen_en      = issue;
  assign issue_valid = issue;
  assign issue_sof   = issue && (x_q == '0) && (y_q == '0);
  assign issue_eol   = issue && x_last;
  assign x_base      = x_q;
  assign y_cur       = y_q;
  assign credits     = credits_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign proto_err   = proto_q;

endmodule
